// File: rtl/signed_serial_addition_pkg.sv
// Shared constants and enumerations for the bit-serial sign-magnitude adder.
// W is the full operand width; MAG is the magnitude width below the sign bit.
package signed_serial_addition_pkg;

    localparam int W     = 16;
    localparam int MAG   = W - 1;
    localparam int CNT_W = $clog2(MAG);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_ADD,
        OP_SUB
    } op_t;

endpackage

// File: rtl/signed_serial_addition_serial_addsub_bit.sv
// One-bit full adder / full subtractor cell used by the serial datapath.
// cout is the carry when adding and the borrow when subtracting (x - y - cin).
module serial_addsub_bit
    import signed_serial_addition_pkg::*;
(
    input  logic x_bit,
    input  logic y_bit,
    input  logic cin,
    input  op_t  op,
    output logic s_bit,
    output logic cout
);

    logic x_xor_y;

    always_comb begin
        x_xor_y = x_bit ^ y_bit;
        s_bit   = x_xor_y ^ cin;
        if (op == OP_ADD) begin
            cout = (x_bit & y_bit) | (cin & x_xor_y);
        end else begin
            cout = (~x_bit & y_bit) | (cin & ~x_xor_y);
        end
    end

endmodule

// File: rtl/signed_serial_addition.sv
// Bit-serial sign-magnitude adder: one magnitude bit per cycle, LSB first,
// with valid/ready handshakes on both the operand and the result side.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CMP   | compare magnitudes, pick operation, order and result sign
// RUN   | one magnitude bit per cycle through the serial cell
// DONE  | out_valid high, result held until out_ready
module signed_serial_addition
    import signed_serial_addition_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         ovf,
    output logic         busy
);

    state_t state, state_nxt;

    logic [W-1:0]     a_q, b_q;
    logic [MAG-1:0]   x_sr, y_sr, res_q;
    logic [CNT_W-1:0] cnt_q;
    op_t              op_q;
    logic             rsign_q;
    logic             carry_q;
    logic [W-1:0]     sum_q;
    logic             ovf_q;

    logic [MAG-1:0] mag_a, mag_b;
    logic           sign_a, sign_b;
    logic           signs_equal, a_greater, mag_tie;
    logic [MAG-1:0] x_init, y_init;
    op_t            op_init;
    logic           rsign_init;

    logic           s_bit, cout;
    logic [MAG-1:0] res_next;
    logic           last_bit;

    // ------------------------------------------------------------------
    // State register and next-state / handshake logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Magnitude compare: -0 has magnitude 0 and simply falls out as zero
    // ------------------------------------------------------------------
    always_comb begin
        mag_a       = a_q[MAG-1:0];
        mag_b       = b_q[MAG-1:0];
        sign_a      = a_q[W-1];
        sign_b      = b_q[W-1];
        signs_equal = (sign_a == sign_b);
        a_greater   = (mag_a > mag_b);
        mag_tie     = (mag_a == mag_b);

        x_init     = mag_a;
        y_init     = mag_b;
        op_init    = OP_ADD;
        rsign_init = sign_a;

        if (!signs_equal) begin
            op_init = OP_SUB;
            if (a_greater || mag_tie) begin
                x_init = mag_a;
                y_init = mag_b;
            end else begin
                x_init = mag_b;
                y_init = mag_a;
            end
            if (mag_tie) begin
                rsign_init = 1'b0;
            end else if (a_greater) begin
                rsign_init = sign_a;
            end else begin
                rsign_init = sign_b;
            end
        end
    end

    serial_addsub_bit u_bit_cell (
        .x_bit (x_sr[0]),
        .y_bit (y_sr[0]),
        .cin   (carry_q),
        .op    (op_q),
        .s_bit (s_bit),
        .cout  (cout)
    );

    // Result bits enter from the MSB side so the LSB lands at bit 0 after MAG shifts.
    assign res_next = {s_bit, res_q[MAG-1:1]};
    assign last_bit = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            x_sr    <= '0;
            y_sr    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            rsign_q <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                CMP: begin
                    x_sr    <= x_init;
                    y_sr    <= y_init;
                    op_q    <= op_init;
                    rsign_q <= rsign_init;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    res_q   <= '0;
                end
                RUN: begin
                    x_sr    <= {1'b0, x_sr[MAG-1:1]};
                    y_sr    <= {1'b0, y_sr[MAG-1:1]};
                    res_q   <= res_next;
                    carry_q <= cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // A zero magnitude never carries a negative sign, even after wrap.
                        sum_q <= {rsign_q & (|res_next), res_next};
                        ovf_q <= (op_q == OP_ADD) & cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum = sum_q;
    assign ovf = ovf_q;

endmodule
